gray_conv_arbiter: RTL
======================

// Module: gray_conv_arbiter
// PURPOSE
//  Shares one registered Gray-to-binary conversion unit among N_REQ requesters.
//  Round-robin arbitration, valid/ready handshake on every requester and on the single response port.
//  Sits between Gray-coded pointer/counter sources (e.g. CDC FIFO pointers) and binary consumers.
//  Sustains one conversion per cycle.
// PARAMETERS
//  N_REQ   4   number of requesters (>=1)
//  W       4   Gray/binary word width (>=1)
//  ID_W    -   localparam: max(1,$clog2(N_REQ)), width of rsp_id
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  req_valid  in   N_REQ      per-requester request valid
//  req_gray   in   N_REQ*W    packed Gray words, requester i at [i*W +: W]
//  req_ready  out  N_REQ      one-hot (or zero) accept strobe
//  rsp_valid  out  1          response valid
//  rsp_ready  in   1          response consumer ready
//  rsp_bin    out  W          converted binary word
//  rsp_id     out  ID_W       index of requester that produced rsp_bin
//  grant_cnt  out  16         accepted-request count (only with GRAY_ARB_CNT_EN)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_bin=0, rsp_id=0, rr_ptr=0, grant_cnt=0.
//  FSM: IDLE (output register empty), RESP (output register full).
//   - can_accept = (state==IDLE) | (rsp_valid & rsp_ready).
//   - IDLE: any req_valid -> accept winner, go RESP; else stay IDLE.
//   - RESP: rsp_ready=0 -> hold; rsp_ready=1 & new winner -> accept same cycle, stay RESP;
//     rsp_ready=1 & no request -> IDLE, rsp_valid=0.
//  Arbitration: round-robin, search starts at rr_ptr, wraps N_REQ-1 -> 0.
//   - on accept of i: rr_ptr <= (i==N_REQ-1) ? 0 : i+1.
//  req_ready[i] = can_accept & grant[i] (combinational; depends on req_valid, rsp_ready).
//  Handshake: transfer when valid & ready same cycle. Requester holds req_valid and req_gray stable until accepted.
//  Datapath: b[W-1]=g[W-1]; b[k]=b[k+1]^g[k]. Computed combinationally on the granted word, registered at accept.
//  Latency: accepted at edge t -> rsp_valid/rsp_bin/rsp_id valid after edge t, i.e. one cycle.
//  Back-pressure: while rsp_valid & !rsp_ready, rsp_bin/rsp_id stable and req_ready==0.
//  Simultaneous: all requesters valid with rsp_ready=1 -> grants 0,1,2,..,N_REQ-1,0,... one per cycle.
//  N_REQ==1: arbitration degenerates, rr_ptr stays 0, rsp_id=0.
//  Reset mid-operation: pending response discarded, no req_ready issued until after release.
// CONFIGURATION
//  GRAY_ARB_CNT_EN defined:
//   - grant_cnt port present.
//   - 16-bit counter, +1 per accepted request, saturates at 16'hFFFF, reset to 0.
//  GRAY_ARB_CNT_EN undefined: grant_cnt port and counter absent, all other behaviour identical.
// STRUCTURE
//  Package gray_arb_pkg:
//   - typedef enum {IDLE, RESP} gray_arb_state_t
//   - GRANT_CNT_W=16, GRANT_CNT_MAX
//  Sub-module gray2bin_core #(W): purely combinational Gray->binary chain.
//   - Instantiated once on the granted word.
//  Top module holds FSM, round-robin pointer/grant logic, output register, optional counter.
// TESTING
//  1 Reset, req_valid=4'b0001, req_gray[3:0]=4'b0110, rsp_ready=1 -> next cycle rsp_valid=1, rsp_bin=4'b0100, rsp_id=0.
//  2 All four valid, rsp_ready=1 held -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, rsp_valid never drops.
//  3 rsp_valid=1, rsp_ready=0 for 3 cycles -> rsp_bin/rsp_id unchanged, req_ready=0; ready=1 -> next grant follows rr_ptr.
//  4 Sweep all 16 Gray codes via requester 2 (e.g. 4'b1000 -> 4'b1111) -> rsp_bin matches model, rsp_id=2.
//  5 Assert rst while rsp_valid=1 -> rsp_valid=0 immediately; after release first grant goes to requester 0.
//  6 GRAY_ARB_CNT_EN: 5 accepts -> grant_cnt=5; counter forced to 16'hFFFE, 3 accepts -> holds 16'hFFFF.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types and constants for the Gray-to-binary conversion arbiter.
// The grant counter width and saturation value are used only when GRAY_ARB_CNT_EN is defined.
package gray_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } gray_arb_state_t;

    localparam int                     GRANT_CNT_W   = 16;
    localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = '1;

endpackage

// File: rtl/gray2bin_core.sv
// Purely combinational Gray-to-binary chain: each binary bit folds in
// every Gray bit above it, starting from the MSB.
module gray2bin_core #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin[W-1] = gray[W-1];
        for (int k = W - 2; k >= 0; k--) begin
            bin[k] = bin[k+1] ^ gray[k];
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray-to-binary converter among N_REQ requesters.
// Define GRAY_ARB_CNT_EN to add the saturating 16-bit grant_cnt output.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_gray,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_bin,
    output logic [ID_W-1:0]    rsp_id
`ifdef GRAY_ARB_CNT_EN
    ,
    output logic [GRANT_CNT_W-1:0] grant_cnt
`endif
);

    gray_arb_state_t  state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_next;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_id;
    logic [W-1:0]     win_gray;
    logic [W-1:0]     win_bin;
    logic             found;
    logic             can_accept;
    logic             accept;
    int               idx;

    // NOTE: every signal gets a default at the top of the block so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        grant    = '0;
        win_id   = '0;
        win_gray = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_id     = ID_W'(idx);
                win_gray   = req_gray[idx*W +: W];
            end
        end
    end

    gray2bin_core #(.W(W)) u_gray2bin (
        .gray (win_gray),
        .bin  (win_bin)
    );

    // Held in reset, nothing may be accepted even though state already reads IDLE.
    assign can_accept = !rst && ((state == IDLE) || (rsp_valid && rsp_ready));
    assign accept     = can_accept && found;
    assign req_ready  = can_accept ? grant : '0;
    assign rr_next    = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_bin   <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_bin   <= win_bin;
                        rsp_id    <= win_id;
                        rr_ptr    <= rr_next;
                    end
                end
                RESP: begin
                    if (accept) begin
                        rsp_bin <= win_bin;
                        rsp_id  <= win_id;
                        rr_ptr  <= rr_next;
                    end else if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRAY_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (accept && (grant_cnt != GRANT_CNT_MAX)) begin
            grant_cnt <= grant_cnt + 1'b1;
        end
    end
`endif

endmodule
